// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stopwatch_ctrl                                               |
// | Description : Button conditioning (sync + debounce + press detect), 0.1 s  |
// |               tick prescaler and mode FSM driving the decade counter's     |
// |               enable, synchronous clear and display freeze.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TICK_DIV        = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_n,
  output logic       tick,
  output logic       clr,
  output logic       freeze,
  output logic       active,
  output logic [2:0] state
);

  // Counter widths; a single-cycle debounce still needs a 1-bit counter.
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = $clog2(TICK_DIV);

  localparam logic [DW-1:0] c_deb_last  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] c_tick_last = PW'(TICK_DIV - 1);

  // Button bit positions within btn_n.
  localparam int c_iniciar = 0;
  localparam int c_reset   = 1;
  localparam int c_contar  = 2;
  localparam int c_pausar  = 3;
  localparam int c_parar   = 4;

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_IDLE = 3'd1,
    S_RUN  = 3'd2,
    S_LAP  = 3'd3
  } state_e;

  logic [4:0] sync1_q;
  logic [4:0] sync2_q;
  logic [4:0] w_press;
  logic [4:0] w_win;
  logic       w_counting;
  logic       w_leave;

  state_e        state_q;
  logic          clr_q;
  logic          freeze_q;
  logic          active_q;
  logic          tick_q;
  logic [PW-1:0] presc_q;

  // Two-stage synchronizer; idles at 1 so a released button reads as released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_btn
      logic [DW-1:0] cnt_q;
      logic          level_q;
      logic          press_q;

      // Accept a new level only after DEBOUNCE_CYCLES consecutive differing
      // samples; flag a one-cycle press on an accepted 1->0 change.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q   <= '0;
          level_q <= 1'b1;
          press_q <= 1'b0;
        end else begin
          press_q <= 1'b0;
          if (sync2_q[gi] == level_q) begin
            cnt_q <= '0;
          end else if (cnt_q == c_deb_last) begin
            cnt_q   <= '0;
            level_q <= sync2_q[gi];
            press_q <= ~sync2_q[gi];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end

      assign w_press[gi] = press_q;
    end
  endgenerate

  // Fixed priority arbitration: parar > reset > pausar > contar > iniciar.
  always_comb begin
    w_win = '0;
    if (w_press[c_parar]) begin
      w_win[c_parar] = 1'b1;
    end else if (w_press[c_reset]) begin
      w_win[c_reset] = 1'b1;
    end else if (w_press[c_pausar]) begin
      w_win[c_pausar] = 1'b1;
    end else if (w_press[c_contar]) begin
      w_win[c_contar] = 1'b1;
    end else if (w_press[c_iniciar]) begin
      w_win[c_iniciar] = 1'b1;
    end
  end

  // In RUN/LAP only reset and parar leave the counting states.
  assign w_counting = (state_q == S_RUN) || (state_q == S_LAP);
  assign w_leave    = w_win[c_reset] || w_win[c_parar];

  // Mode FSM; every output is registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_OFF;
      clr_q    <= 1'b0;
      freeze_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      case (state_q)
        S_OFF: begin
          if (w_win[c_iniciar]) begin
            state_q  <= S_IDLE;
            active_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (w_win[c_contar]) begin
            state_q <= S_RUN;
          end else if (w_win[c_reset]) begin
            clr_q <= 1'b1;
          end else if (w_win[c_parar]) begin
            state_q  <= S_OFF;
            active_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_win[c_pausar]) begin
            state_q  <= S_LAP;
            freeze_q <= 1'b1;
          end else if (w_win[c_reset]) begin
            state_q <= S_IDLE;
            clr_q   <= 1'b1;
          end else if (w_win[c_parar]) begin
            // Counter value is kept on stop; no clear here.
            state_q  <= S_OFF;
            active_q <= 1'b0;
          end
        end
        S_LAP: begin
          if (w_win[c_contar]) begin
            state_q  <= S_RUN;
            freeze_q <= 1'b0;
          end else if (w_win[c_reset]) begin
            state_q  <= S_IDLE;
            clr_q    <= 1'b1;
            freeze_q <= 1'b0;
          end else if (w_win[c_parar]) begin
            state_q  <= S_OFF;
            freeze_q <= 1'b0;
            active_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_OFF;
          freeze_q <= 1'b0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  // Tick prescaler: free-runs through RUN<->LAP, cleared on any exit to
  // IDLE/OFF so a clear never coincides with a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else if (w_counting && !w_leave) begin
      if (presc_q == c_tick_last) begin
        presc_q <= '0;
        tick_q  <= 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
        tick_q  <= 1'b0;
      end
    end else begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end
  end

  assign tick   = tick_q;
  assign clr    = clr_q;
  assign freeze = freeze_q;
  assign active = active_q;
  assign state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_stopwatch_ctrl                                            |
// | Description : Directed scenarios plus randomized button traffic checked    |
// |               against a behavioural model of the stopwatch controller.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_stopwatch_ctrl;

  localparam int DEB  = 4;
  localparam int TDIV = 10;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [4:0] btn_n = 5'b11111;
  logic       tick;
  logic       clr;
  logic       freeze;
  logic       active;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_DIV       (TDIV)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_n),
    .tick  (tick),
    .clr   (clr),
    .freeze(freeze),
    .active(active),
    .state (state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // mode: 0 OFF, 1 IDLE, 2 RUN, 3 LAP. A button level is accepted once the
  // last DEB synchronized samples (raw delayed two edges) all disagree with it.
  int       m_mode  = 0;
  int       m_presc = 0;
  int       m_win_b = -1;
  int       m_next  = 0;
  bit       m_tick  = 1'b0;
  bit       m_clr   = 1'b0;
  bit       m_alldiff;
  bit [4:0] m_press = '0;
  bit [4:0] m_lvl   = '1;
  bit [4:0] m_rd1   = '1;
  bit [4:0] m_rd2   = '1;
  bit [4:0] m_s;
  bit [4:0] m_hist [DEB];

  task automatic model_step();
    if (rst) begin
      m_mode = 0; m_presc = 0; m_tick = 1'b0; m_clr = 1'b0;
      m_press = '0; m_lvl = '1; m_rd1 = '1; m_rd2 = '1;
      for (int k = 0; k < DEB; k++) m_hist[k] = '1;
    end else begin
      m_win_b = -1;
      if (m_press[4])      m_win_b = 4;
      else if (m_press[1]) m_win_b = 1;
      else if (m_press[3]) m_win_b = 3;
      else if (m_press[2]) m_win_b = 2;
      else if (m_press[0]) m_win_b = 0;
      m_next = m_mode;
      m_clr  = 1'b0;
      case (m_mode)
        0: if (m_win_b == 0) m_next = 1;
        1: begin
          if (m_win_b == 2) m_next = 2;
          if (m_win_b == 1) m_clr = 1'b1;
          if (m_win_b == 4) m_next = 0;
        end
        default: begin
          if (m_win_b == 3) m_next = 3;
          if (m_win_b == 2) m_next = 2;
          if (m_win_b == 1) begin m_clr = 1'b1; m_next = 1; end
          if (m_win_b == 4) m_next = 0;
        end
      endcase
      if (m_mode >= 2 && m_next >= 2) begin
        if (m_presc == TDIV - 1) begin m_presc = 0; m_tick = 1'b1; end
        else begin m_presc = m_presc + 1; m_tick = 1'b0; end
      end else begin
        m_presc = 0; m_tick = 1'b0;
      end
      m_mode = m_next;
      m_s   = m_rd2;
      m_rd2 = m_rd1;
      m_rd1 = btn_n;
      for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_s;
      m_press = '0;
      for (int b = 0; b < 5; b++) begin
        m_alldiff = 1'b1;
        for (int k = 0; k < DEB; k++) if (m_hist[k][b] == m_lvl[b]) m_alldiff = 1'b0;
        if (m_alldiff) begin
          m_lvl[b]   = ~m_lvl[b];
          m_press[b] = ~m_lvl[b];
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < DEB; k++) m_hist[k] = '1;
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic press_hold(input int b, input int n);
    btn_n    = 5'b11111;
    btn_n[b] = 1'b0;
    repeat (n) @(negedge clk);
    btn_n = 5'b11111;
  endtask

  task automatic drive_idle(input int n);
    btn_n = 5'b11111;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst   = 1'b1;
    btn_n = 5'b11111;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({state, freeze, active, clr, tick} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_hold: got %b want %b", {state, freeze, active, clr, tick}, 7'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({state, freeze, active, clr, tick} !== 7'b0) begin
        n_err++;
        $display("FAIL off_idle cyc=%0d: got %b want %b", i, {state, freeze, active, clr, tick}, 7'b0);
      end
    end
  endtask

  task automatic test_start_run();
    int cnt, last, bad;
    btn_n    = 5'b11111;
    btn_n[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 6) begin
        n_cmp++;
        if (state !== 3'd0) begin n_err++; $display("FAIL iniciar_early: state %0d want 0", state); end
      end
      if (i == 7) begin
        n_cmp++;
        if (state !== 3'd1 || active !== 1'b1) begin
          n_err++; $display("FAIL iniciar_latency: state %0d active %b want 1/1", state, active);
        end
      end
    end
    drive_idle(10);
    btn_n[2] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 6) begin
        n_cmp++;
        if (state !== 3'd1) begin n_err++; $display("FAIL contar_early: state %0d want 1", state); end
      end
      if (i == 7) begin
        n_cmp++;
        if (state !== 3'd2) begin n_err++; $display("FAIL contar_latency: state %0d want 2", state); end
      end
    end
    btn_n = 5'b11111;
    cnt = 0; last = -1; bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        cnt++;
        if (last >= 0 && i - last != TDIV) bad++;
        last = i;
      end
    end
    n_cmp++;
    if (cnt !== 10) begin n_err++; $display("FAIL tick_count: got %0d want 10", cnt); end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL tick_spacing: %0d bad gaps want 0", bad); end
  endtask

  task automatic test_glitch();
    int nclr, bad;
    nclr     = 0;
    btn_n    = 5'b11111;
    btn_n[1] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (clr === 1'b1) nclr++;
      if (i == 7) begin
        n_cmp++;
        if (state !== 3'd1 || clr !== 1'b1 || tick !== 1'b0) begin
          n_err++;
          $display("FAIL run_reset: state %0d clr %b tick %b want 1/1/0", state, clr, tick);
        end
      end
    end
    drive_idle(10);
    n_cmp++;
    if (nclr !== 1) begin n_err++; $display("FAIL run_reset_clr_width: got %0d cycles want 1", nclr); end
    btn_n[2] = 1'b0;
    repeat (3) @(negedge clk);
    btn_n = 5'b11111;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (state !== 3'd1) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL glitch_reject: %0d cycles off IDLE want 0", bad); end
    btn_n[2] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 6) begin
        n_cmp++;
        if (state !== 3'd1) begin n_err++; $display("FAIL hold6_early: state %0d want 1", state); end
        btn_n = 5'b11111;
      end
      if (i == 7) begin
        n_cmp++;
        if (state !== 3'd2) begin n_err++; $display("FAIL hold6_latency: state %0d want 2", state); end
      end
    end
    drive_idle(10);
  endtask

  task automatic test_lap();
    bit found;
    int last, bad;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (tick === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL lap_tick_wait: tick %b want a tick within 30 cycles", tick); end
    btn_n[3] = 1'b0;
    last = 0; bad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 20) btn_n = 5'b11111;
      if (tick === 1'b1) begin
        if (i - last != TDIV) bad++;
        last = i;
      end
      if (i == 7) begin
        n_cmp++;
        if (state !== 3'd3 || freeze !== 1'b1 || active !== 1'b1) begin
          n_err++; $display("FAIL pausar_lap: state %0d freeze %b want 3/1", state, freeze);
        end
      end
    end
    n_cmp++;
    if (bad !== 0 || last !== 40) begin
      n_err++; $display("FAIL lap_tick_phase: %0d bad gaps last %0d want 0/40", bad, last);
    end
    btn_n[2] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 7) begin
        n_cmp++;
        if (state !== 3'd2 || freeze !== 1'b0) begin
          n_err++; $display("FAIL lap_resume: state %0d freeze %b want 2/0", state, freeze);
        end
      end
    end
    drive_idle(10);
  endtask

  task automatic test_simultaneous();
    int nclr;
    nclr     = 0;
    btn_n    = 5'b11111;
    btn_n[3] = 1'b0;
    btn_n[4] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (clr === 1'b1) nclr++;
      if (i == 7) begin
        n_cmp++;
        if (state !== 3'd0 || freeze !== 1'b0 || active !== 1'b0 || tick !== 1'b0) begin
          n_err++;
          $display("FAIL parar_wins: state %0d freeze %b active %b tick %b want 0/0/0/0", state, freeze, active, tick);
        end
      end
    end
    drive_idle(10);
    n_cmp++;
    if (nclr !== 0) begin n_err++; $display("FAIL parar_no_clr: got %0d clr cycles want 0", nclr); end
    press_hold(2, 20);
    drive_idle(5);
    n_cmp++;
    if (state !== 3'd0 || active !== 1'b0) begin
      n_err++; $display("FAIL off_ignores_contar: state %0d active %b want 0/0", state, active);
    end
  endtask

  task automatic test_clear_and_async_reset();
    bit found;
    int bad;
    press_hold(0, 20);
    drive_idle(10);
    press_hold(2, 20);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (tick === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL clr_tick_wait: tick %b want a tick within 30 cycles", tick); end
    // Prescaler is 0 here; the press acts on the edge where it holds 5.
    repeat (9) @(negedge clk);
    btn_n[1] = 1'b0;
    for (int m = 10; m <= 30; m++) begin
      @(negedge clk);
      if (m == 16) begin
        n_cmp++;
        if (clr !== 1'b1 || tick !== 1'b0 || state !== 3'd1 || freeze !== 1'b0) begin
          n_err++;
          $display("FAIL presc5_clear: clr %b tick %b state %0d want 1/0/1", clr, tick, state);
        end
      end
      if (m == 17) begin
        n_cmp++;
        if (clr !== 1'b0) begin n_err++; $display("FAIL clr_width: clr %b want 0", clr); end
      end
    end
    btn_n = 5'b11111;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tick !== 1'b0 || state !== 3'd1) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL idle_no_tick: %0d bad cycles want 0", bad); end
    press_hold(2, 20);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (tick === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL async_tick_wait: tick %b want a tick within 30 cycles", tick); end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({state, freeze, active, clr, tick} !== 7'b0) begin
      n_err++; $display("FAIL async_reset: got %b want %b", {state, freeze, active, clr, tick}, 7'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_idle(5);
  endtask

  task automatic test_random();
    logic [6:0] got, expv;
    int         len;
    int         pct [5];
    pct[0] = 30; pct[1] = 10; pct[2] = 30; pct[3] = 20; pct[4] = 8;
    for (int seg = 0; seg < 180; seg++) begin
      btn_n = 5'b11111;
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 99) < pct[b]) btn_n[b] = 1'b0;
      len = $urandom_range(1, 14);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        got  = {state, freeze, active, clr, tick};
        expv = {3'(m_mode), (m_mode == 3), (m_mode != 0), m_clr, m_tick};
        n_cmp++;
        if (got !== expv) begin
          n_err++; $display("FAIL random_cycle seg=%0d: got %b want %b", seg, got, expv);
        end
      end
      if ($urandom_range(0, 39) == 0) begin
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({state, freeze, active, clr, tick} !== 7'b0) begin
          n_err++; $display("FAIL random_async_reset seg=%0d: got %b want %b", seg, {state, freeze, active, clr, tick}, 7'b0);
        end
        @(negedge clk);
        rst = 1'b0;
      end
    end
    btn_n = 5'b11111;
  endtask

  initial begin
    test_reset();
    test_start_run();
    test_glitch();
    test_lap();
    test_simultaneous();
    test_clear_and_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
